// File: rtl/dds_capture_la.sv
// Logic-analyser capture into a DEPTH-sample ring buffer with a pre-trigger window.
// Defining DDS_CAPTURE_TRIG_CNT_EN adds a trig_count input: fire on the (trig_count+1)-th event.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | no capture in progress, buffer frozen
// PRE_FILL  | writing the pre-trigger samples, trigger ignored
// WAIT_TRIG | writing continuously (ring wraps), waiting for a trigger
// POST      | writing the post-trigger samples
// DONE      | capture complete, buffer readable
module dds_capture_la #(
    parameter int DATA_W = 72,
    parameter int TRIG_W = 25,
    parameter int ADDR_W = 10
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [DATA_W-1:0] data_i,
    input  logic [TRIG_W-1:0] trig_i,
    input  logic [TRIG_W-1:0] trig_mask,
    input  logic [TRIG_W-1:0] trig_value,
    input  logic              trig_mode,
    input  logic [ADDR_W-1:0] pre_trig,
    input  logic              arm,
    input  logic              abort,
    input  logic              force_trig,
`ifdef DDS_CAPTURE_TRIG_CNT_EN
    input  logic [15:0]       trig_count,
`endif
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              triggered,
    output logic              done,
    output logic [ADDR_W-1:0] trig_addr
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        PRE_FILL,
        WAIT_TRIG,
        POST,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] pre_lat;
    logic [ADDR_W-1:0] post_len;
    logic [ADDR_W-1:0] rd_idx;
    logic              match, match_d, qual, fire, wr_en;

`ifdef DDS_CAPTURE_TRIG_CNT_EN
    logic [15:0] evt_q, evt_d, cnt_lat;
`endif

    assign match = ((trig_i ^ trig_value) & trig_mask) == '0;
    assign qual  = trig_mode ? (match & ~match_d) : match;

`ifdef DDS_CAPTURE_TRIG_CNT_EN
    assign fire = (state_q == WAIT_TRIG) && (force_trig || (qual && (evt_q == cnt_lat)));
`else
    assign fire = (state_q == WAIT_TRIG) && (force_trig || qual);
`endif

    // pre_trig is ADDR_W wide, so it can never exceed DEPTH-1: saturation is implicit.
    assign post_len = ADDR_W'(DEPTH - 1) - pre_lat;
    assign wr_en    = ((state_q == PRE_FILL) || (state_q == WAIT_TRIG) || (state_q == POST))
                      && !arm && !abort;
    assign rd_idx   = trig_addr - pre_lat + rd_addr;
    assign busy     = (state_q == PRE_FILL) || (state_q == WAIT_TRIG) || (state_q == POST);
    assign done     = (state_q == DONE);

    // cnt_q is a down-counter of remaining writes in PRE_FILL and POST.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef DDS_CAPTURE_TRIG_CNT_EN
        evt_d   = evt_q;
`endif
        if (abort) begin
            state_d = IDLE;
        end else if (arm) begin
            cnt_d   = pre_trig;
            state_d = (pre_trig == '0) ? WAIT_TRIG : PRE_FILL;
`ifdef DDS_CAPTURE_TRIG_CNT_EN
            evt_d   = '0;
`endif
        end else begin
            case (state_q)
                PRE_FILL: begin
                    cnt_d = cnt_q - ADDR_W'(1);
                    if (cnt_q == ADDR_W'(1)) state_d = WAIT_TRIG;
                end
                WAIT_TRIG: begin
                    if (fire) begin
                        cnt_d   = post_len;
                        state_d = (post_len == '0) ? DONE : POST;
                    end
`ifdef DDS_CAPTURE_TRIG_CNT_EN
                    else if (qual) begin
                        evt_d = evt_q + 16'd1;
                    end
`endif
                end
                POST: begin
                    cnt_d = cnt_q - ADDR_W'(1);
                    if (cnt_q == ADDR_W'(1)) state_d = DONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_ptr    <= '0;
            pre_lat   <= '0;
            match_d   <= 1'b0;
            triggered <= 1'b0;
            trig_addr <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
`ifdef DDS_CAPTURE_TRIG_CNT_EN
            evt_q     <= '0;
            cnt_lat   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            match_d <= match;
`ifdef DDS_CAPTURE_TRIG_CNT_EN
            evt_q   <= evt_d;
`endif
            if (abort) begin
                triggered <= 1'b0;
            end else if (arm) begin
                wr_ptr    <= '0;
                pre_lat   <= pre_trig;
                triggered <= 1'b0;
`ifdef DDS_CAPTURE_TRIG_CNT_EN
                cnt_lat   <= trig_count;
`endif
            end else begin
                if (wr_en) wr_ptr <= wr_ptr + ADDR_W'(1);
                if (fire) begin
                    triggered <= 1'b1;
                    trig_addr <= wr_ptr;
                end
            end
            if (rd_en && (state_q == DONE)) begin
                rd_data  <= mem[rd_idx];
                rd_valid <= 1'b1;
            end else begin
                rd_valid <= 1'b0;
            end
        end
    end

    // Buffer RAM carries no reset so it maps onto block memory.
    always_ff @(posedge sys_clk) begin
        if (wr_en) mem[wr_ptr] <= data_i;
    end

endmodule

// File: tb/tb_dds_capture_la.sv
// Self-checking bench for dds_capture_la (ADDR_W=4) against a sample-stream reference model.
// Define DDS_CAPTURE_TRIG_CNT_EN to also exercise the trigger event counter.
module tb_dds_capture_la;

    localparam int DATA_W = 72;
    localparam int TRIG_W = 25;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam int MAXN   = 128;

    logic              sys_clk;
    logic              sys_rst_n;
    logic [DATA_W-1:0] data_i;
    logic [TRIG_W-1:0] trig_i, trig_mask, trig_value;
    logic              trig_mode;
    logic [ADDR_W-1:0] pre_trig;
    logic              arm, abort, force_trig;
`ifdef DDS_CAPTURE_TRIG_CNT_EN
    logic [15:0]       trig_count;
`endif
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid, busy, triggered, done;
    logic [ADDR_W-1:0] trig_addr;

    int errors = 0;
    int checks = 0;

    // Stimulus stream: entry j is driven in the j-th cycle after the arm cycle.
    logic [DATA_W-1:0] data_seq  [MAXN];
    logic [TRIG_W-1:0] trig_seq  [MAXN];
    bit                force_seq [MAXN];
    logic [DATA_W-1:0] last_rd;

    dds_capture_la #(.DATA_W(DATA_W), .TRIG_W(TRIG_W), .ADDR_W(ADDR_W)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .data_i     (data_i),
        .trig_i     (trig_i),
        .trig_mask  (trig_mask),
        .trig_value (trig_value),
        .trig_mode  (trig_mode),
        .pre_trig   (pre_trig),
        .arm        (arm),
        .abort      (abort),
        .force_trig (force_trig),
`ifdef DDS_CAPTURE_TRIG_CNT_EN
        .trig_count (trig_count),
`endif
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .busy       (busy),
        .triggered  (triggered),
        .done       (done),
        .trig_addr  (trig_addr)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    function automatic bit is_match(logic [TRIG_W-1:0] t, logic [TRIG_W-1:0] m,
                                    logic [TRIG_W-1:0] v);
        return ((t ^ v) & m) == '0;
    endfunction

    // Index of the trigger sample in the stream, or -1 if the stream never triggers.
    function automatic int model_k(int pre, bit mode, logic [TRIG_W-1:0] m,
                                   logic [TRIG_W-1:0] v, logic [TRIG_W-1:0] arm_trig, int cnt);
        int events = 0;
        for (int j = pre; j < MAXN; j++) begin
            bit now  = is_match(trig_seq[j], m, v);
            bit prev = (j == 0) ? is_match(arm_trig, m, v) : is_match(trig_seq[j-1], m, v);
            bit q    = mode ? (now && !prev) : now;
            if (force_seq[j]) return j;
            if (q) begin
                if (events == cnt) return j;
                events++;
            end
        end
        return -1;
    endfunction

    task automatic fill_random();
        for (int j = 0; j < MAXN; j++) begin
            data_seq[j]  = DATA_W'({$urandom, $urandom, $urandom});
            trig_seq[j]  = TRIG_W'($urandom);
            force_seq[j] = 1'b0;
        end
    endtask

    task automatic drive_idle();
        arm = 0; abort = 0; force_trig = 0; rd_en = 0; rd_addr = '0;
        trig_i = '0; data_i = '0;
    endtask

    task automatic run_capture(string name, int pre, bit mode, logic [TRIG_W-1:0] m,
                               logic [TRIG_W-1:0] v, logic [TRIG_W-1:0] arm_trig, int cnt);
        int k, jd;
        logic [DATA_W-1:0] exp_d;
        k = model_k(pre, mode, m, v, arm_trig, cnt);
        if (k < 0) begin
            errors++;
            $display("FAIL %s stimulus: stream contains no trigger", name);
            return;
        end
        jd = k + DEPTH - 1 - pre;
        @(negedge sys_clk);
        arm = 1; pre_trig = ADDR_W'(pre); trig_mode = mode; trig_mask = m; trig_value = v;
        trig_i = arm_trig; data_i = DATA_W'({$urandom, $urandom, $urandom}); force_trig = 0;
`ifdef DDS_CAPTURE_TRIG_CNT_EN
        trig_count = 16'(cnt);
`endif
        for (int j = 0; j <= jd + 1; j++) begin
            @(negedge sys_clk);
            if (j > 0) begin
                if (j - 1 == k - 1) begin
                    checks++;
                    if (triggered !== 1'b0 || busy !== 1'b1) begin
                        errors++;
                        $display("FAIL %s pre-trigger status: triggered=%b busy=%b want 0/1",
                                 name, triggered, busy);
                    end
                end
                if (j - 1 == k) begin
                    checks++;
                    if (triggered !== 1'b1) begin
                        errors++;
                        $display("FAIL %s trigger cycle %0d: triggered=%b want 1", name, k, triggered);
                    end
                end
                if (j - 1 == jd - 1) begin
                    checks++;
                    if (done !== 1'b0 || busy !== 1'b1) begin
                        errors++;
                        $display("FAIL %s before last write: done=%b busy=%b want 0/1", name, done, busy);
                    end
                end
                if (j - 1 == jd) begin
                    checks++;
                    if (done !== 1'b1 || busy !== 1'b0) begin
                        errors++;
                        $display("FAIL %s after last write: done=%b busy=%b want 1/0", name, done, busy);
                    end
                end
            end
            arm = 0;
            if (j <= jd) begin
                data_i = data_seq[j]; trig_i = trig_seq[j]; force_trig = force_seq[j];
            end else begin
                data_i = '0; trig_i = '0; force_trig = 0;
            end
        end
        checks++;
        if (trig_addr !== ADDR_W'(k % DEPTH)) begin
            errors++;
            $display("FAIL %s trig_addr: got %0d want %0d", name, trig_addr, k % DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) begin
            rd_en = 1; rd_addr = ADDR_W'(i);
            @(negedge sys_clk);
            rd_en = 0;
            exp_d = data_seq[k - pre + i];
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== exp_d) begin
                errors++;
                $display("FAIL %s read[%0d]: valid=%b data=%h want 1/%h", name, i, rd_valid, rd_data, exp_d);
            end
            last_rd = exp_d;
            if ($urandom_range(0, 1) == 1) @(negedge sys_clk);
        end
        @(negedge sys_clk);
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== last_rd) begin
            errors++;
            $display("FAIL %s read hold: valid=%b data=%h want 0/%h", name, rd_valid, rd_data, last_rd);
        end
    endtask

    task automatic test_reset();
        drive_idle();
        trig_mask = '0; trig_value = '0; trig_mode = 0; pre_trig = '0;
        sys_rst_n = 0;
        #12;
        checks++;
        if ({busy, triggered, done, rd_valid} !== 4'b0 || rd_data !== '0 || trig_addr !== '0) begin
            errors++;
            $display("FAIL reset outputs: busy=%b trig=%b done=%b valid=%b data=%h taddr=%0d want all 0",
                     busy, triggered, done, rd_valid, rd_data, trig_addr);
        end
        @(negedge sys_clk);
        sys_rst_n = 1;
        rd_en = 1;
        @(negedge sys_clk);
        rd_en = 0;
        checks++;
        if (rd_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle read: valid=%b busy=%b want 0/0", rd_valid, busy);
        end
    endtask

    task automatic test_level_window();
        for (int j = 0; j < MAXN; j++) begin
            data_seq[j] = DATA_W'(j); trig_seq[j] = TRIG_W'(j); force_seq[j] = 0;
        end
        run_capture("level_window", 4, 0, 25'h1FFFFFF, 25'd20, 25'h1FFFFFF, 0);
    endtask

    task automatic test_edge_held();
        logic [TRIG_W-1:0] v = 25'h0ABCDE;
        fill_random();
        for (int j = 0; j < MAXN; j++) trig_seq[j] = '0;
        for (int j = 0; j < 10; j++) trig_seq[j] = v;
        for (int j = 12; j < 16; j++) trig_seq[j] = v;
        run_capture("edge_held", 3, 1, 25'h1FFFFFF, v, v, 0);
    endtask

    task automatic test_pre_zero();
        fill_random();
        run_capture("pre_zero", 0, 0, '0, TRIG_W'($urandom), TRIG_W'($urandom), 0);
    endtask

    task automatic test_pre_max_wrap();
        logic [TRIG_W-1:0] m = TRIG_W'($urandom) | 25'h1;
        logic [TRIG_W-1:0] v = TRIG_W'($urandom);
        fill_random();
        trig_seq[40] = v;
        run_capture("pre_max_wrap", 15, 0, m, v, ~v, 0);
    endtask

    task automatic test_force();
        fill_random();
        force_seq[9] = 1;
        run_capture("force", 6, 1, 25'h1FFFFFF, 25'h1555555, 25'h0, 0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            int pre = $urandom_range(0, 15);
            bit mode = 1'($urandom_range(0, 1));
            logic [TRIG_W-1:0] m = TRIG_W'($urandom) | 25'h1;
            logic [TRIG_W-1:0] v = TRIG_W'($urandom);
            logic [TRIG_W-1:0] at = TRIG_W'($urandom);
            int p = pre + $urandom_range(0, 30);
            fill_random();
            trig_seq[p] = v;
            if (p > 0) trig_seq[p-1] = v ^ m; else at = v ^ m;
            if ($urandom_range(0, 2) == 0) force_seq[pre + $urandom_range(0, 30)] = 1;
            run_capture("random", pre, mode, m, v, at, 0);
        end
    endtask

    task automatic test_abort_arm();
        fill_random();
        @(negedge sys_clk);
        arm = 1; pre_trig = '0; trig_mask = '0; trig_mode = 0;
        for (int j = 0; j < 4; j++) begin
            @(negedge sys_clk);
            arm = 0; data_i = data_seq[j];
        end
        arm = 1; abort = 1; pre_trig = 4'd3;
        @(negedge sys_clk);
        arm = 0; abort = 0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || triggered !== 1'b0) begin
            errors++;
            $display("FAIL abort_arm status: busy=%b done=%b trig=%b want 0/0/0", busy, done, triggered);
        end
        rd_en = 1;
        @(negedge sys_clk);
        rd_en = 0;
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== last_rd) begin
            errors++;
            $display("FAIL abort_arm read: valid=%b data=%h want 0/%h", rd_valid, rd_data, last_rd);
        end
        repeat (3) @(negedge sys_clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_arm stays idle: busy=%b done=%b want 0/0", busy, done);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge sys_clk);
        arm = 1; pre_trig = 4'd2; trig_mask = '0; trig_mode = 0;
        for (int j = 0; j < 6; j++) begin
            @(negedge sys_clk);
            arm = 0; data_i = DATA_W'(j + 100);
        end
        #2 sys_rst_n = 0;
        #1;
        checks++;
        if ({busy, triggered, done, rd_valid} !== 4'b0 || rd_data !== '0 || trig_addr !== '0) begin
            errors++;
            $display("FAIL reset_mid outputs: busy=%b trig=%b done=%b valid=%b data=%h taddr=%0d want all 0",
                     busy, triggered, done, rd_valid, rd_data, trig_addr);
        end
        @(negedge sys_clk);
        sys_rst_n = 1;
        fill_random();
        trig_seq[20] = 25'h1234567 & 25'h1FFFFFF;
        run_capture("after_reset", 5, 0, 25'h1FFFFFF, 25'h1234567 & 25'h1FFFFFF, 25'h0, 0);
    endtask

`ifdef DDS_CAPTURE_TRIG_CNT_EN
    task automatic test_trig_count();
        logic [TRIG_W-1:0] v = 25'h0F0F0F;
        fill_random();
        for (int j = 0; j < MAXN; j++) trig_seq[j] = '0;
        trig_seq[5] = v; trig_seq[9] = v; trig_seq[13] = v;
        run_capture("trig_count", 1, 0, 25'h1FFFFFF, v, 25'h0, 2);
        fill_random();
        for (int j = 0; j < MAXN; j++) trig_seq[j] = '0;
        trig_seq[3] = v; force_seq[6] = 1;
        run_capture("trig_count_force", 1, 0, 25'h1FFFFFF, v, 25'h0, 2);
    endtask
`endif

    initial begin
        last_rd = '0;
        test_reset();
        test_level_window();
        test_edge_held();
        test_pre_zero();
        test_pre_max_wrap();
        test_force();
        test_random();
        test_abort_arm();
        test_reset_mid();
`ifdef DDS_CAPTURE_TRIG_CNT_EN
        test_trig_count();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dds_capture_la.md
DDS_CAPTURE_LA -- requirements
Module: dds_capture_la

Interface
REQ-001 Parameter DATA_W, default 72, width of the captured sample bus.
REQ-002 Parameter TRIG_W, default 25, width of the trigger-compare bus.
REQ-003 Parameter ADDR_W, default 10, buffer address width; DEPTH = 2^ADDR_W samples.
REQ-004 Port sys_clk  in  1  single clock; all logic SHALL be sampled on its rising edge.
REQ-005 Port sys_rst_n  in  1  asynchronous active-low reset.
REQ-006 Port data_i  in  DATA_W  sample written every capture cycle.
REQ-007 Port trig_i  in  TRIG_W  trigger-compare input.
REQ-008 Port trig_mask / trig_value  in  TRIG_W each  bit enables and compare values.
REQ-009 Port trig_mode  in  1  0 = level match, 1 = rising edge of match.
REQ-010 Port pre_trig  in  ADDR_W  pre-trigger sample count, latched on arm.
REQ-011 Port arm / abort / force_trig  in  1 each  single-cycle control pulses.
REQ-012 Port rd_en  in  1  read strobe; rd_addr  in  ADDR_W  offset from the oldest captured sample.
REQ-013 Port rd_data  out  DATA_W  read data; rd_valid  out  1  read-data qualifier.
REQ-014 Port busy / triggered / done  out  1 each  status; trig_addr  out  ADDR_W  physical address of the trigger sample.

Function
REQ-015 The state machine SHALL have the states IDLE, PRE_FILL, WAIT_TRIG, POST and DONE.
- REQ-016 arm in any state SHALL latch pre_trig (saturated to DEPTH-1), clear wr_ptr and the counters, and enter PRE_FILL.
- If the latched pre_trig is 0, arm SHALL enter WAIT_TRIG directly.
REQ-017 abort SHALL return the block to IDLE from any state; abort SHALL win over a simultaneous arm.
REQ-018 In PRE_FILL, WAIT_TRIG and POST, the block SHALL write data_i to mem[wr_ptr] every cycle, and wr_ptr SHALL increment modulo DEPTH (wrap-around).
- REQ-019 PRE_FILL SHALL last exactly pre_trig write cycles, then move to WAIT_TRIG.
- Trigger conditions during PRE_FILL SHALL be ignored.
REQ-020 match = (((trig_i XOR trig_value) AND trig_mask) == 0).
- match_d SHALL be match registered every cycle; match_d resets to 0.
- An all-zero mask SHALL always match.
REQ-021 In WAIT_TRIG, the trigger SHALL fire on any of: (trig_mode=0 AND match), (trig_mode=1 AND match AND NOT match_d), or force_trig.
- The sample written in the firing cycle is the trigger sample.
- trig_addr SHALL be set to that cycle's wr_ptr.
- triggered SHALL be set.
- The block SHALL enter POST.
REQ-022 POST SHALL write exactly DEPTH-1-pre_trig further samples, then enter DONE.
- If that count is 0, the firing cycle SHALL go directly to DONE.
- Total capture SHALL be DEPTH samples.
REQ-023 busy SHALL be 1 in PRE_FILL, WAIT_TRIG and POST; done SHALL be 1 only in DONE.
REQ-024 In DONE, rd_en SHALL return mem[(trig_addr - pre_trig + rd_addr) mod DEPTH] on rd_data, with rd_valid=1, one cycle later.
- rd_en outside DONE SHALL give rd_valid=0, and rd_data SHALL hold its previous value.
REQ-025 No writes SHALL occur in IDLE or DONE.
- Buffer contents SHALL persist until the next arm.

Reset
REQ-026 When sys_rst_n goes low, the block SHALL immediately:
- enter IDLE;
- drive busy, triggered, done and rd_valid to 0;
- zero rd_data, trig_addr, wr_ptr, the counters, the latched pre_trig and match_d.
REQ-027 Reset mid-capture SHALL abandon the capture; buffer RAM contents are not reset.

Configuration
REQ-028 The macro DDS_CAPTURE_TRIG_CNT_EN, when defined, SHALL add input trig_count (16 bits, latched on arm).
- The trigger SHALL fire on the (trig_count+1)-th qualifying event in WAIT_TRIG.
- force_trig SHALL still fire immediately.
- When the macro is undefined, the port SHALL be absent and the first qualifying event SHALL fire.

Verification
REQ-029 ADDR_W=4, pre_trig=4, data_i=cycle count, trig_mode=0, mask=0x1FFFFFF, trigger value hit on data cycle 20 -> done after 11 POST writes; rd_addr 0..15 returns 16..31; trig_addr=20 mod 16=4.
REQ-030 trig_mode=1 with match held high from before WAIT_TRIG -> no trigger until match falls and rises again; the trigger sample is the rising cycle.
REQ-031 pre_trig=0 and mask=0 -> trigger on the first WAIT_TRIG cycle; rd_addr 0 returns the first sample after arm.
REQ-032 arm and abort in the same cycle during POST -> IDLE, busy=0, done=0; rd_en gives rd_valid=0.
REQ-033 sys_rst_n pulsed low mid-POST -> all outputs 0 immediately; a fresh arm then completes a capture normally.
REQ-034 With DDS_CAPTURE_TRIG_CNT_EN defined and trig_count=2, three match pulses -> trigger on the third; force_trig fires on the first cycle of assertion.
